// File: rtl/pd_ana_pkg.sv
// rtl/pd_ana_pkg.sv - shared types and constants for the VBUS analog transition path
//
// Purpose: FSM state encoding, PDO type codes, request unit multipliers and
// default vSafe5V / current-limit setpoints used by pd_vbus_ramp_ctrl.
// Ports: none (package).
package pd_ana_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RAMP   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } ana_state_e;

  typedef enum logic {
    PDO_FIXED = 1'b0,
    PDO_PPS   = 1'b1
  } pdo_type_e;

  // Multipliers from request units to 10 mV / 10 mA units.
  localparam int unsigned VMUL_FIXED = 5;  // 50 mV -> 10 mV
  localparam int unsigned VMUL_PPS   = 2;  // 20 mV -> 10 mV
  localparam int unsigned IMUL_FIXED = 1;  // 10 mA -> 10 mA
  localparam int unsigned IMUL_PPS   = 5;  // 50 mA -> 10 mA

  localparam int unsigned VSAFE_DEF = 500;  // vSafe5V, 10 mV units
  localparam int unsigned IDEF_DEF  = 300;  // default current limit, 10 mA units

  // 10-bit request field times a small multiplier; 1023*5 fits in 13 bits.
  function automatic logic [12:0] scale_req(input logic [9:0] val, input int unsigned mul);
    return {3'b000, val} * 13'(mul);
  endfunction

endpackage

// File: rtl/pd_tick_gen.sv
// rtl/pd_tick_gen.sv - free-running ramp tick generator
//
// Purpose: divides clk by TICK_CYC; tick is high for one cycle when the
// counter sits at TICK_CYC-1 (the wrap point). Never restarted by requests.
// Ports:
//   clk   in   system clock
//   rst_n in   asynchronous active-low reset
//   tick  out  one-cycle pulse every TICK_CYC cycles
module pd_tick_gen #(
  parameter int unsigned TICK_CYC = 24
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(TICK_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/pd_vbus_ramp_ctrl.sv
// rtl/pd_vbus_ramp_ctrl.sv - slew-limited VBUS setpoint controller for PD transitions
//
// Purpose: accepts a policy-engine transition request, converts it to 10 mV /
// 10 mA units, ramps the DAC setpoint toward the clamped target by at most
// VSTEP per tick, waits SETTLE_TICKS, then checks measured VBUS against the
// target and reports completion (with timeout error) to the policy engine.
// Detach returns the supply to vSafe5V without reporting.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   ana2pe_attached_i             port attached level
//   pe2ana_trans_en_i             one-cycle request strobe
//   pe2ana_trans_pdotype_i        0 fixed, 1 PPS
//   pe2ana_trans_voltage_i [9:0]  requested voltage (50 mV fixed / 20 mV PPS)
//   pe2ana_trans_current_i [9:0]  requested current (10 mA fixed / 50 mA PPS)
//   vbus_meas_i [12:0]            ADC VBUS, 10 mV units
//   ana2pe_trans_finish_o         one-cycle completion pulse
//   trans_err_o                   1 = tolerance timeout, valid with finish
//   dac_vset_o [12:0]             VBUS DAC setpoint, 10 mV units
//   ilim_set_o [12:0]             current limit, 10 mA units
//   busy_o                        transition in progress
module pd_vbus_ramp_ctrl
  import pd_ana_pkg::*;
#(
  parameter int unsigned TICK_CYC      = 24,
  parameter int unsigned VSTEP         = 3,
  parameter int unsigned SETTLE_TICKS  = 10,
  parameter int unsigned TIMEOUT_TICKS = 100,
  parameter int unsigned VTOL          = 25,
  parameter int unsigned VMIN          = 330,
  parameter int unsigned VMAX          = 2100,
  parameter int unsigned VSAFE         = VSAFE_DEF,
  parameter int unsigned IDEF          = IDEF_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ana2pe_attached_i,
  input  logic        pe2ana_trans_en_i,
  input  logic        pe2ana_trans_pdotype_i,
  input  logic [9:0]  pe2ana_trans_voltage_i,
  input  logic [9:0]  pe2ana_trans_current_i,
  input  logic [12:0] vbus_meas_i,
  output logic        ana2pe_trans_finish_o,
  output logic        trans_err_o,
  output logic [12:0] dac_vset_o,
  output logic [12:0] ilim_set_o,
  output logic        busy_o
);

  localparam int unsigned CNT_MAX = (SETTLE_TICKS > TIMEOUT_TICKS) ? SETTLE_TICKS : TIMEOUT_TICKS;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  ana_state_e  state_q;
  logic [12:0] dac_q, ilim_q, target_q;
  logic        finish_q, err_q, busy_q;
  logic [CW-1:0] settle_cnt_q, tout_cnt_q;
  logic [CW-1:0] settle_cnt_d, tout_cnt_d;

  logic        tick;
  logic [12:0] vt_raw, vt_clamped, it_conv;
  logic        ramp_up;
  logic [12:0] ramp_dist, meas_dist;

  pd_tick_gen #(.TICK_CYC(TICK_CYC)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Request conversion is evaluated every cycle but only used on accept.
  always_comb begin
    if (pdo_type_e'(pe2ana_trans_pdotype_i) == PDO_PPS) begin
      vt_raw  = scale_req(pe2ana_trans_voltage_i, VMUL_PPS);
      it_conv = scale_req(pe2ana_trans_current_i, IMUL_PPS);
    end else begin
      vt_raw  = scale_req(pe2ana_trans_voltage_i, VMUL_FIXED);
      it_conv = scale_req(pe2ana_trans_current_i, IMUL_FIXED);
    end
    vt_clamped = vt_raw;
    if (vt_raw < 13'(VMIN)) begin
      vt_clamped = 13'(VMIN);
    end else if (vt_raw > 13'(VMAX)) begin
      vt_clamped = 13'(VMAX);
    end
  end

  // Unsigned magnitudes; computing the larger-minus-smaller avoids signed math.
  assign ramp_up      = (target_q >= dac_q);
  assign ramp_dist    = ramp_up ? (target_q - dac_q) : (dac_q - target_q);
  assign meas_dist    = (vbus_meas_i >= target_q) ? (vbus_meas_i - target_q) : (target_q - vbus_meas_i);
  assign settle_cnt_d = settle_cnt_q + CW'(1);
  assign tout_cnt_d   = tout_cnt_q + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      dac_q        <= 13'(VSAFE);
      ilim_q       <= 13'(IDEF);
      target_q     <= 13'(VSAFE);
      finish_q     <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      settle_cnt_q <= '0;
      tout_cnt_q   <= '0;
    end else begin
      finish_q <= 1'b0;
      if (!ana2pe_attached_i) begin
        // Detach wins over everything, including a same-cycle request.
        state_q <= ST_IDLE;
        dac_q   <= 13'(VSAFE);
        ilim_q  <= 13'(IDEF);
        busy_q  <= 1'b0;
      end else if (pe2ana_trans_en_i) begin
        // Accept in any state; a retarget ramps on from the present dac_q.
        target_q <= vt_clamped;
        ilim_q   <= it_conv;
        busy_q   <= 1'b1;
        err_q    <= 1'b0;
        state_q  <= ST_RAMP;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
          end
          ST_RAMP: begin
            if (tick) begin
              if (ramp_dist <= 13'(VSTEP)) begin
                dac_q        <= target_q;
                settle_cnt_q <= '0;
                state_q      <= ST_SETTLE;
              end else if (ramp_up) begin
                dac_q <= dac_q + 13'(VSTEP);
              end else begin
                dac_q <= dac_q - 13'(VSTEP);
              end
            end
          end
          ST_SETTLE: begin
            if (tick) begin
              settle_cnt_q <= settle_cnt_d;
              if (settle_cnt_d == CW'(SETTLE_TICKS)) begin
                tout_cnt_q <= '0;
                state_q    <= ST_CHECK;
              end
            end
          end
          ST_CHECK: begin
            if (tick) begin
              if (meas_dist <= 13'(VTOL)) begin
                state_q  <= ST_DONE;
                finish_q <= 1'b1;
                err_q    <= 1'b0;
                busy_q   <= 1'b0;
              end else begin
                tout_cnt_q <= tout_cnt_d;
                if (tout_cnt_d == CW'(TIMEOUT_TICKS)) begin
                  state_q  <= ST_DONE;
                  finish_q <= 1'b1;
                  err_q    <= 1'b1;
                  busy_q   <= 1'b0;
                end
              end
            end
          end
          // finish_q/err_q were loaded on entry, so DONE lasts exactly one cycle.
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign ana2pe_trans_finish_o = finish_q;
  assign trans_err_o           = err_q;
  assign dac_vset_o            = dac_q;
  assign ilim_set_o            = ilim_q;
  assign busy_o                = busy_q;

endmodule

// File: tb/tb_pd_vbus_ramp_ctrl.sv
// tb/tb_pd_vbus_ramp_ctrl.sv - self-checking bench for pd_vbus_ramp_ctrl
module tb_pd_vbus_ramp_ctrl;

  localparam int TICK    = 24;
  localparam int VSTEP   = 3;
  localparam int SETTLE  = 10;
  localparam int TIMEOUT = 100;
  localparam int VTOL    = 25;
  localparam int VMIN    = 330;
  localparam int VMAX    = 2100;

  logic        clk, rst_n, attached, trans_en, pdotype;
  logic [9:0]  voltage, current;
  logic [12:0] vbus_meas, dac_vset, ilim_set;
  logic        finish, trans_err, busy;

  int nvec = 0;
  int nerr = 0;
  int m_dac;

  pd_vbus_ramp_ctrl #(
    .TICK_CYC(TICK), .VSTEP(VSTEP), .SETTLE_TICKS(SETTLE), .TIMEOUT_TICKS(TIMEOUT),
    .VTOL(VTOL), .VMIN(VMIN), .VMAX(VMAX), .VSAFE(500), .IDEF(300)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .ana2pe_attached_i     (attached),
    .pe2ana_trans_en_i     (trans_en),
    .pe2ana_trans_pdotype_i(pdotype),
    .pe2ana_trans_voltage_i(voltage),
    .pe2ana_trans_current_i(current),
    .vbus_meas_i           (vbus_meas),
    .ana2pe_trans_finish_o (finish),
    .trans_err_o           (trans_err),
    .dac_vset_o            (dac_vset),
    .ilim_set_o            (ilim_set),
    .busy_o                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    nvec++;
    if (act < lo || act > hi) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Reference conversion straight from the unit definitions.
  function automatic int model_vt(input bit pps, input int v);
    int r;
    r = pps ? v * 2 : v * 5;
    if (r < VMIN) r = VMIN;
    if (r > VMAX) r = VMAX;
    return r;
  endfunction

  function automatic int model_it(input bit pps, input int i);
    return pps ? i * 5 : i;
  endfunction

  task automatic issue(input bit pps, input int v, input int i);
    pdotype  = pps;
    voltage  = 10'(v);
    current  = 10'(i);
    trans_en = 1'b1;
    @(negedge clk);
    trans_en = 1'b0;
  endtask

  // Observe one transition from accept (sample 0) to finish and beyond.
  task automatic watch(input string nm, input int start, input int tgt, input int exp_err, input bit track);
    int prev, steps, bad, first_chg, last_chg, nfin, fin_cyc, err_seen, busy_bad;
    int cur, d_old, d_new, lat, budget, exp_steps;
    bit ok;
    prev = start; steps = 0; bad = 0; first_chg = -1; last_chg = -1;
    nfin = 0; fin_cyc = -1; err_seen = -1; busy_bad = 0;
    exp_steps = (iabs(tgt - start) + VSTEP - 1) / VSTEP;
    lat = exp_err ? (SETTLE + TIMEOUT) * TICK : (SETTLE + 1) * TICK;
    budget = (exp_steps + SETTLE + TIMEOUT + 4) * TICK;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      cur = int'(dac_vset);
      if (cur != prev) begin
        steps++;
        if (first_chg < 0) first_chg = c;
        last_chg = c;
        d_old = iabs(prev - tgt);
        d_new = iabs(cur - tgt);
        ok = (d_new < d_old) &&
             ((d_old - d_new == VSTEP && ((cur >= tgt) == (prev >= tgt))) ||
              (d_new == 0 && d_old <= VSTEP));
        if (!ok) bad++;
        prev = cur;
      end
      if (finish) begin
        nfin++;
        if (fin_cyc < 0) begin
          fin_cyc  = c;
          err_seen = int'(trans_err);
        end
      end else if (fin_cyc < 0 && !busy) begin
        busy_bad++;
      end
      if (track) vbus_meas = dac_vset;
      if (fin_cyc >= 0 && c >= fin_cyc + 40) break;
    end
    chk({nm, " finish_count"}, nfin, 1);
    chk({nm, " ramp_steps"}, steps, exp_steps);
    chk({nm, " bad_steps"}, bad, 0);
    chk({nm, " busy_drop_early"}, busy_bad, 0);
    chk({nm, " final_dac"}, int'(dac_vset), tgt);
    chk({nm, " err_at_finish"}, err_seen, exp_err);
    chk({nm, " err_held"}, int'(trans_err), exp_err);
    chk({nm, " busy_after"}, int'(busy), 0);
    if (steps > 0) begin
      chk_rng({nm, " first_step_lat"}, first_chg, 1, TICK);
      chk({nm, " end_to_finish"}, fin_cyc - last_chg, lat);
    end else begin
      chk_rng({nm, " accept_to_finish"}, fin_cyc, lat + 1, lat + TICK);
    end
  endtask

  task automatic xfer(input string nm, input bit pps, input int v, input int i,
                      input int exp_t, input int exp_i, input bit track, input int meas);
    int e;
    vbus_meas = track ? 13'(m_dac) : 13'(meas);
    issue(pps, v, i);
    chk({nm, " ilim"}, int'(ilim_set), exp_i);
    chk({nm, " busy"}, int'(busy), 1);
    e = track ? 0 : ((iabs(meas - exp_t) > VTOL) ? 1 : 0);
    watch(nm, m_dac, exp_t, e, track);
    m_dac = exp_t;
  endtask

  // Follow an upward ramp for n steps, each exactly +VSTEP.
  task automatic ramp_steps(input int start, input int n, output int bad);
    int prev, cnt;
    prev = start; cnt = 0; bad = 0;
    for (int c = 0; c < (n + 2) * TICK && cnt < n; c++) begin
      @(negedge clk);
      vbus_meas = dac_vset;
      if (int'(dac_vset) != prev) begin
        if (int'(dac_vset) != prev + VSTEP) bad++;
        prev = int'(dac_vset);
        cnt++;
      end
    end
    if (cnt < n) bad++;
  endtask

  typedef struct {
    bit pps;
    int v;
    int i;
    int exp_t;
    int exp_i;
  } vec_t;

  initial begin
    vec_t tbl[8];
    int   bad, nfin, v, i, t, il, off;
    bit   pps, track;

    tbl[0] = '{1'b0, 180,  300,  900,  300};
    tbl[1] = '{1'b1, 165,   60,  330,  300};
    tbl[2] = '{1'b0,  66,    5,  330,    5};
    tbl[3] = '{1'b1, 100,   10,  330,   50};
    tbl[4] = '{1'b0, 120,  250,  600,  250};
    tbl[5] = '{1'b1, 400,   20,  800,  100};
    tbl[6] = '{1'b0, 1023, 1023, 2100, 1023};
    tbl[7] = '{1'b1, 1023, 1023, 2046, 5115};

    rst_n = 1'b1; attached = 1'b0; trans_en = 1'b0; pdotype = 1'b0;
    voltage = '0; current = '0; vbus_meas = 13'd500;
    #1 rst_n = 1'b0;
    #1;
    chk("rst dac", int'(dac_vset), 500);
    chk("rst ilim", int'(ilim_set), 300);
    chk("rst finish", int'(finish), 0);
    chk("rst err", int'(trans_err), 0);
    chk("rst busy", int'(busy), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; attached = 1'b1;
    @(negedge clk);

    // Asynchronous reset in the middle of a ramp.
    issue(1'b0, 180, 123);
    chk("prerst ilim", int'(ilim_set), 123);
    for (int c = 0; c < 2 * TICK && int'(dac_vset) == 500; c++) @(negedge clk);
    chk("prerst first_step", int'(dac_vset), 503);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst dac", int'(dac_vset), 500);
    chk("midrst ilim", int'(ilim_set), 300);
    chk("midrst finish", int'(finish), 0);
    chk("midrst busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_dac = 500;

    // Detach mid-ramp, with a simultaneous request that must lose.
    issue(1'b0, 240, 50);
    ramp_steps(500, 67, bad);
    chk("detach ramp_shape", bad, 0);
    chk("detach pre_dac", int'(dac_vset), 701);
    attached = 1'b0;
    issue(1'b0, 180, 222);
    chk("detach dac", int'(dac_vset), 500);
    chk("detach ilim", int'(ilim_set), 300);
    chk("detach busy", int'(busy), 0);
    nfin = 0;
    for (int c = 0; c < 15 * TICK; c++) begin
      @(negedge clk);
      if (finish) nfin++;
    end
    chk("detach no_finish", nfin, 0);
    issue(1'b0, 200, 111);
    chk("detached req busy", int'(busy), 0);
    chk("detached req ilim", int'(ilim_set), 300);
    attached = 1'b1;
    @(negedge clk);

    // Retarget mid-ramp to a clamped low target; ramp reverses from 602.
    vbus_meas = 13'd500;
    issue(1'b0, 180, 200);
    ramp_steps(500, 34, bad);
    chk("retarget ramp_shape", bad, 0);
    chk("retarget pre_dac", int'(dac_vset), 602);
    issue(1'b0, 0, 77);
    chk("retarget ilim", int'(ilim_set), 77);
    chk("retarget busy", int'(busy), 1);
    watch("retarget", 602, 330, 0, 1'b1);
    m_dac = 330;

    for (int k = 0; k < 8; k++)
      xfer($sformatf("tbl%0d", k), tbl[k].pps, tbl[k].v, tbl[k].i,
           tbl[k].exp_t, tbl[k].exp_i, 1'b1, 0);

    for (int r = 0; r < 5; r++) begin
      pps = 1'($urandom_range(0, 1));
      if (pps) v = m_dac / 2 + int'($urandom_range(0, 120)) - 60;
      else     v = m_dac / 5 + int'($urandom_range(0, 56)) - 28;
      if (v < 0) v = 0;
      if (v > 1023) v = 1023;
      i = int'($urandom_range(0, 1023));
      t = model_vt(pps, v);
      il = model_it(pps, i);
      track = 1'($urandom_range(0, 1));
      off = int'($urandom_range(0, 60)) - 30;
      xfer($sformatf("rnd%0d", r), pps, v, i, t, il, track, t + off);
    end

    // Measured VBUS stuck at 5 V: ramp completes, then tolerance timeout.
    xfer("timeout", 1'b0, 240, 300, 1200, 300, 1'b0, 500);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
